q_neighbor_table: RTL and testbench

Parametrised neighbour table for the EER-RL node with a built-in sequential best-hop search. It stores up to DEPTH neighbours, each with ID, hop count, Q-value, residual energy and hops-to-CH. Entries are updated in place by ID. On request it scans all valid entries and returns the one with the highest Q-value. It sits between the packet-field decode path and the reward/transmit path, and replaces the fixed-size table and the separate find-max-best step.

---
 rtl/q_nt_pkg.sv | 15 +
 rtl/nt_best_cmp.sv | 12 +
 rtl/q_neighbor_table.sv | 212 +++++++++++++++++++++
 tb/tb_q_neighbor_table.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/q_nt_pkg.sv
// Shared types for the neighbour table and other Q-value selection blocks.
package q_nt_pkg;
  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} nt_state_t;

  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] chhops;
  } nt_entry_t;
endpackage

// File: rtl/nt_best_cmp.sv
// Better-than test on (qvalue, hops): higher Q wins, equal Q falls back to fewer hops.
module nt_best_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] cand_q,
  input  logic [W-1:0] cand_hops,
  input  logic [W-1:0] ref_q,
  input  logic [W-1:0] ref_hops,
  output logic         better
);
  assign better = (cand_q > ref_q) || ((cand_q == ref_q) && (cand_hops < ref_hops));
endmodule

// File: rtl/q_neighbor_table.sv
// Neighbour table with in-place update by ID and a one-entry-per-cycle best-hop scan.
// Optional macro NT_AGING_EN: hb_reset ages entries instead of clearing the table.
module q_neighbor_table
  import q_nt_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int AGE_LIMIT  = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_id,
  input  logic [WORD_WIDTH-1:0] wr_hops,
  input  logic [WORD_WIDTH-1:0] wr_qvalue,
  input  logic [WORD_WIDTH-1:0] wr_energy,
  input  logic [WORD_WIDTH-1:0] wr_chhops,
  output logic                  wr_drop,
  input  logic                  hb_reset,
  input  logic                  srch_start,
  output logic                  busy,
  output logic                  srch_done,
  output logic                  best_valid,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_qvalue,
  output logic [WORD_WIDTH-1:0] best_hops,
  output logic [IDX_W-1:0]      best_idx,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_id,
  output logic [WORD_WIDTH-1:0] rd_hops,
  output logic [WORD_WIDTH-1:0] rd_qvalue,
  output logic [WORD_WIDTH-1:0] rd_energy,
  output logic [WORD_WIDTH-1:0] rd_chhops,
  output logic [IDX_W:0]        count
);
  // Same layout as nt_entry_t, sized by this instance's WORD_WIDTH.
  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] chhops;
  } row_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  row_t             tbl [DEPTH];
  row_t             wr_row, rd_row;
  nt_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx, hit_idx, free_idx, wr_idx, run_idx;
  logic             any_hit, any_free, wr_acc, wr_do, take, cmp_better;
  logic             run_valid;
  logic [WORD_WIDTH-1:0] run_id, run_q, run_hops;
  wire              unused_age = (AGE_LIMIT != 0);

  assign wr_ready  = (state == IDLE);
  assign busy      = !wr_ready;
  assign srch_done = (state == DONE);
  assign wr_acc    = wr_en && wr_ready && !hb_reset;
  assign wr_do     = wr_acc && (any_hit || any_free);
  assign wr_idx    = any_hit ? hit_idx : free_idx;
  assign wr_row    = '{valid: 1'b1, id: wr_id, hops: wr_hops, qvalue: wr_qvalue,
                       energy: wr_energy, chhops: wr_chhops};

  // Descending walk leaves the lowest free index in free_idx.
  always_comb begin
    any_hit  = 1'b0;
    any_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    count    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].id == wr_id) begin
        any_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!tbl[i].valid) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      count = count + {{IDX_W{1'b0}}, tbl[i].valid};
    end
  end

`ifdef NT_AGING_EN
  logic [1:0] age [DEPTH];
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
`ifdef NT_AGING_EN
        age[i] <= '0;
`endif
      end
    end else if (hb_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef NT_AGING_EN
        if (tbl[i].valid) begin
          if (int'(age[i]) + 1 >= AGE_LIMIT) begin
            tbl[i].valid <= 1'b0;
            age[i]       <= '0;
          end else begin
            age[i] <= age[i] + 2'd1;
          end
        end
`else
        tbl[i].valid <= 1'b0;
`endif
      end
    end else if (wr_do) begin
      tbl[wr_idx] <= wr_row;
`ifdef NT_AGING_EN
      age[wr_idx] <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_drop <= 1'b0;
    else       wr_drop <= wr_acc && !any_hit && !any_free;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (srch_start) state_nxt = SCAN;
      SCAN:    if (hb_reset || idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  nt_best_cmp #(.W(WORD_WIDTH)) u_cmp (
    .cand_q   (tbl[idx].qvalue),
    .cand_hops(tbl[idx].hops),
    .ref_q    (run_q),
    .ref_hops (run_hops),
    .better   (cmp_better)
  );

  // Strictly-better only, so full ties stay with the earlier (lower) index.
  assign take = tbl[idx].valid && (!run_valid || cmp_better);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      idx         <= '0;
      run_valid   <= 1'b0;
      run_id      <= '0;
      run_q       <= '0;
      run_hops    <= '0;
      run_idx     <= '0;
      best_valid  <= 1'b0;
      best_id     <= '0;
      best_qvalue <= '0;
      best_hops   <= '0;
      best_idx    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && srch_start) begin
        idx       <= '0;
        run_valid <= 1'b0;
        run_id    <= '0;
        run_q     <= '0;
        run_hops  <= '0;
        run_idx   <= '0;
      end else if (state == SCAN) begin
        if (hb_reset) begin
          best_valid  <= 1'b0;
          best_id     <= '0;
          best_qvalue <= '0;
          best_hops   <= '0;
          best_idx    <= '0;
        end else begin
          idx <= idx + 1'b1;
          if (take) begin
            run_valid <= 1'b1;
            run_id    <= tbl[idx].id;
            run_q     <= tbl[idx].qvalue;
            run_hops  <= tbl[idx].hops;
            run_idx   <= idx;
          end
          if (idx == LAST) begin
            best_valid  <= take || run_valid;
            best_id     <= take ? tbl[idx].id     : run_id;
            best_qvalue <= take ? tbl[idx].qvalue : run_q;
            best_hops   <= take ? tbl[idx].hops   : run_hops;
            best_idx    <= take ? idx             : run_idx;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rd_row <= '0;
    else       rd_row <= tbl[rd_idx].valid ? tbl[rd_idx] : '0;
  end

  assign rd_valid  = rd_row.valid;
  assign rd_id     = rd_row.id;
  assign rd_hops   = rd_row.hops;
  assign rd_qvalue = rd_row.qvalue;
  assign rd_energy = rd_row.energy;
  assign rd_chhops = rd_row.chhops;
endmodule

// File: tb/tb_q_neighbor_table.sv
// Directed bench for q_neighbor_table; inputs driven and outputs sampled on the falling edge.
module tb_q_neighbor_table;
  localparam int W = 16;
  localparam int DEPTH = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          wr_en = 1'b0, wr_ready, wr_drop, hb_reset = 1'b0, srch_start = 1'b0;
  logic [W-1:0]  wr_id = '0, wr_hops = '0, wr_qvalue = '0, wr_energy = '0, wr_chhops = '0;
  logic          busy, srch_done, best_valid, rd_valid;
  logic [W-1:0]  best_id, best_qvalue, best_hops;
  logic [IW-1:0] best_idx, rd_idx = '0;
  logic [W-1:0]  rd_id, rd_hops, rd_qvalue, rd_energy, rd_chhops;
  logic [IW:0]   count;

  int checks = 0;
  int fails = 0;
  logic last_drop;
  int   lat;

  always #5 clk = ~clk;

  q_neighbor_table #(.WORD_WIDTH(W), .DEPTH(DEPTH), .IDX_W(IW), .AGE_LIMIT(3)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_ready(wr_ready), .wr_id(wr_id),
    .wr_hops(wr_hops), .wr_qvalue(wr_qvalue), .wr_energy(wr_energy), .wr_chhops(wr_chhops),
    .wr_drop(wr_drop), .hb_reset(hb_reset), .srch_start(srch_start), .busy(busy),
    .srch_done(srch_done), .best_valid(best_valid), .best_id(best_id),
    .best_qvalue(best_qvalue), .best_hops(best_hops), .best_idx(best_idx),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_id(rd_id), .rd_hops(rd_hops),
    .rd_qvalue(rd_qvalue), .rd_energy(rd_energy), .rd_chhops(rd_chhops), .count(count)
  );

  task automatic do_reset();
    @(negedge clk) nrst = 1'b0;
    @(negedge clk) nrst = 1'b1;
  endtask

  task automatic do_write(input logic [W-1:0] id, input logic [W-1:0] hops, input logic [W-1:0] q);
    @(negedge clk);
    wr_en = 1'b1; wr_id = id; wr_hops = hops; wr_qvalue = q;
    wr_energy = id + 16'd1; wr_chhops = 16'd2;
    @(negedge clk);
    wr_en = 1'b0;
    last_drop = wr_drop;
  endtask

  task automatic do_read(input logic [IW-1:0] i);
    @(negedge clk) rd_idx = i;
    @(negedge clk);
  endtask

  task automatic hb_pulse();
    @(negedge clk) hb_reset = 1'b1;
    @(negedge clk) hb_reset = 1'b0;
  endtask

  // Returns cycles from the start edge to the srch_done cycle (DEPTH+1 expected).
  task automatic do_search(output int cyc);
    @(negedge clk) srch_start = 1'b1;
    @(negedge clk) srch_start = 1'b0;
    cyc = 1;
    while (!srch_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++; if (count !== 0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_ready got ready=%b busy=%b want 1/0", wr_ready, busy); end
    checks++; if (srch_done !== 1'b0 || wr_drop !== 1'b0) begin fails++; $display("FAIL reset_pulses got done=%b drop=%b want 0/0", srch_done, wr_drop); end
    checks++; if (best_valid !== 1'b0 || best_id !== 0 || best_idx !== 0) begin fails++; $display("FAIL reset_best got v=%b id=%h idx=%0d want 0", best_valid, best_id, best_idx); end
    checks++; if (rd_valid !== 1'b0 || rd_id !== 0) begin fails++; $display("FAIL reset_rd got v=%b id=%h want 0", rd_valid, rd_id); end
  endtask

  task automatic test_empty();
    do_reset();
    do_search(lat);
    checks++; if (lat !== DEPTH + 1) begin fails++; $display("FAIL empty_latency got %0d want %0d", lat, DEPTH + 1); end
    checks++; if (best_valid !== 1'b0 || best_id !== 0 || best_qvalue !== 0) begin fails++; $display("FAIL empty_best got v=%b id=%h q=%h want 0", best_valid, best_id, best_qvalue); end
  endtask

  task automatic test_insert();
    do_reset();
    do_write(16'h0011, 16'd1, 16'h0100);
    do_write(16'h0022, 16'd2, 16'h0300);
    do_write(16'h0033, 16'd3, 16'h0200);
    checks++; if (count !== 3) begin fails++; $display("FAIL insert_count got %0d want 3", count); end
    do_read(4'd1);
    checks++; if (rd_valid !== 1'b1 || rd_id !== 16'h0022 || rd_qvalue !== 16'h0300) begin fails++; $display("FAIL insert_read got v=%b id=%h q=%h want 1/0022/0300", rd_valid, rd_id, rd_qvalue); end
    checks++; if (rd_hops !== 16'd2 || rd_energy !== 16'h0023 || rd_chhops !== 16'd2) begin fails++; $display("FAIL insert_fields got h=%0d e=%h c=%0d want 2/0023/2", rd_hops, rd_energy, rd_chhops); end
    do_read(4'd5);
    checks++; if (rd_valid !== 1'b0 || rd_id !== 0 || rd_qvalue !== 0) begin fails++; $display("FAIL read_invalid got v=%b id=%h q=%h want 0", rd_valid, rd_id, rd_qvalue); end
  endtask

  task automatic test_update_search();
    do_write(16'h0011, 16'd1, 16'h0400);
    checks++; if (count !== 3) begin fails++; $display("FAIL update_count got %0d want 3", count); end
    do_search(lat);
    checks++; if (lat !== DEPTH + 1) begin fails++; $display("FAIL search_latency got %0d want %0d", lat, DEPTH + 1); end
    checks++; if (best_valid !== 1'b1 || best_id !== 16'h0011 || best_idx !== 0 || best_qvalue !== 16'h0400) begin fails++; $display("FAIL search_best got v=%b id=%h idx=%0d q=%h want 1/0011/0/0400", best_valid, best_id, best_idx, best_qvalue); end
  endtask

  // A write held during a scan waits; a second srch_start mid-scan is ignored.
  task automatic test_back_to_back();
    int cyc;
    @(negedge clk) srch_start = 1'b1;
    @(negedge clk) srch_start = 1'b0;
    wr_en = 1'b1; wr_id = 16'h0044; wr_hops = 16'd9; wr_qvalue = 16'h0050;
    wr_energy = 16'h0045; wr_chhops = 16'd2;
    checks++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin fails++; $display("FAIL busy_flags got busy=%b ready=%b want 1/0", busy, wr_ready); end
    @(negedge clk);
    @(negedge clk) srch_start = 1'b1;
    @(negedge clk) srch_start = 1'b0;
    cyc = 4;
    while (!srch_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== DEPTH + 1) begin fails++; $display("FAIL restart_ignored got %0d want %0d", cyc, DEPTH + 1); end
    checks++; if (count !== 3) begin fails++; $display("FAIL busy_write_held got %0d want 3", count); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got %b want 0", busy); end
    @(negedge clk) wr_en = 1'b0;
    checks++; if (count !== 4) begin fails++; $display("FAIL held_write_taken got %0d want 4", count); end
  endtask

  task automatic test_tie_break();
    do_reset();
    do_write(16'h0051, 16'd3, 16'h0200);
    do_write(16'h0052, 16'd2, 16'h0200);
    do_search(lat);
    checks++; if (best_id !== 16'h0052 || best_idx !== 1 || best_hops !== 16'd2) begin fails++; $display("FAIL tie_hops got id=%h idx=%0d h=%0d want 0052/1/2", best_id, best_idx, best_hops); end
    do_write(16'h0053, 16'd2, 16'h0200);
    do_search(lat);
    checks++; if (best_id !== 16'h0052 || best_idx !== 1) begin fails++; $display("FAIL tie_index got id=%h idx=%0d want 0052/1", best_id, best_idx); end
  endtask

  task automatic test_start_with_write();
    int cyc;
    do_reset();
    @(negedge clk);
    wr_en = 1'b1; srch_start = 1'b1; wr_id = 16'h0061; wr_hops = 16'd1; wr_qvalue = 16'h0010;
    @(negedge clk);
    wr_en = 1'b0; srch_start = 1'b0;
    cyc = 1;
    while (!srch_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== DEPTH + 1 || best_valid !== 1'b1 || best_id !== 16'h0061) begin fails++; $display("FAIL same_cycle got cyc=%0d v=%b id=%h want %0d/1/0061", cyc, best_valid, best_id, DEPTH + 1); end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_write(16'h0100 + 16'(i), 16'd1, 16'(i));
    checks++; if (count !== DEPTH) begin fails++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
    do_write(16'h0999, 16'd1, 16'hFFFF);
    checks++; if (last_drop !== 1'b1 || count !== DEPTH) begin fails++; $display("FAIL drop got drop=%b count=%0d want 1/%0d", last_drop, count, DEPTH); end
    @(negedge clk);
    checks++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL drop_pulse got %b want 0", wr_drop); end
    do_write(16'h0105, 16'd1, 16'hFFFF);
    checks++; if (last_drop !== 1'b0) begin fails++; $display("FAIL full_update_drop got %b want 0", last_drop); end
    do_search(lat);
    checks++; if (best_id !== 16'h0105 || best_idx !== 5 || best_qvalue !== 16'hFFFF) begin fails++; $display("FAIL full_best got id=%h idx=%0d q=%h want 0105/5/ffff", best_id, best_idx, best_qvalue); end
  endtask

  task automatic test_hb_midscan();
    @(negedge clk) srch_start = 1'b1;
    @(negedge clk) srch_start = 1'b0;
    repeat (4) @(negedge clk);
    hb_reset = 1'b1;
    @(negedge clk) hb_reset = 1'b0;
    checks++; if (srch_done !== 1'b1 || best_valid !== 1'b0 || best_id !== 0) begin fails++; $display("FAIL hb_abort got done=%b v=%b id=%h want 1/0/0", srch_done, best_valid, best_id); end
`ifdef NT_AGING_EN
    checks++; if (count !== DEPTH) begin fails++; $display("FAIL hb_abort_count got %0d want %0d", count, DEPTH); end
`else
    checks++; if (count !== 0) begin fails++; $display("FAIL hb_abort_count got %0d want 0", count); end
`endif
  endtask

  task automatic test_hb_write();
    do_reset();
    do_write(16'h0081, 16'd1, 16'h0001);
    @(negedge clk);
    hb_reset = 1'b1; wr_en = 1'b1; wr_id = 16'h0082;
    @(negedge clk);
    hb_reset = 1'b0; wr_en = 1'b0;
`ifdef NT_AGING_EN
    checks++; if (count !== 1) begin fails++; $display("FAIL hb_write_discard got %0d want 1", count); end
`else
    checks++; if (count !== 0) begin fails++; $display("FAIL hb_write_discard got %0d want 0", count); end
`endif
  endtask

`ifdef NT_AGING_EN
  task automatic test_aging();
    do_reset();
    do_write(16'h0071, 16'd1, 16'h0010);
    do_write(16'h0072, 16'd1, 16'h0020);
    hb_pulse();
    do_write(16'h0071, 16'd1, 16'h0010);
    hb_pulse();
    checks++; if (count !== 2) begin fails++; $display("FAIL age_round2 got %0d want 2", count); end
    do_write(16'h0071, 16'd1, 16'h0010);
    hb_pulse();
    checks++; if (count !== 1) begin fails++; $display("FAIL age_expire got %0d want 1", count); end
    do_read(4'd1);
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL age_b_gone got %b want 0", rd_valid); end
    do_read(4'd0);
    checks++; if (rd_valid !== 1'b1 || rd_id !== 16'h0071) begin fails++; $display("FAIL age_a_kept got v=%b id=%h want 1/0071", rd_valid, rd_id); end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    nrst = 1'b1;
    test_empty();
    test_insert();
    test_update_search();
    test_back_to_back();
    test_tie_break();
    test_start_with_write();
    test_full_drop();
    test_hb_midscan();
    test_hb_write();
`ifdef NT_AGING_EN
    test_aging();
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
